// File: rtl/reg_dump_if.sv
// reg_dump_if: command, register-file read port and output stream of the register dump sequencer.
//   master: dump requester / register file / stream sink (drives start, range, abort, rd_data, out_ready)
//   slave : the dump sequencer (drives rd_addr, out_valid, out_data, out_addr, busy, done, word_cnt)
interface reg_dump_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          start;
    logic [AW-1:0] first_reg;
    logic [AW-1:0] last_reg;
    logic          abort;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          busy;
    logic          done;
    logic [AW:0]   word_cnt;

    modport master (
        output start, first_reg, last_reg, abort, rd_data, out_ready,
        input  rd_addr, out_valid, out_data, out_addr, busy, done, word_cnt
    );

    modport slave (
        input  start, first_reg, last_reg, abort, rd_data, out_ready,
        output rd_addr, out_valid, out_data, out_addr, busy, done, word_cnt
    );
endinterface

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks a register range through a register-file read port and streams each value out over valid/ready.
//   clk   : clock, all state changes on posedge
//   rst_n : asynchronous active-low reset
//   bus   : reg_dump_if slave (start/first_reg/last_reg/abort command, rd_addr/rd_data read port,
//           out_valid/out_ready/out_data/out_addr stream, busy/done/word_cnt status)
module reg_dump_reader #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input logic       clk,
    input logic       rst_n,
    reg_dump_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // The end test is an equality compare, so a range ending at the top index stops there without wrapping.
    always_comb begin
        state_nx = state;
        bus.busy = state != IDLE;
        bus.done = state == DONE;
        case (state)
            IDLE:    if (bus.start) state_nx = bus.first_reg <= bus.last_reg ? FETCH : DONE;
            FETCH:   state_nx = bus.abort ? IDLE : SEND;
            SEND:    state_nx = bus.abort ? IDLE : !bus.out_ready ? SEND : bus.rd_addr == last_q ? DONE : FETCH;
            default: state_nx = IDLE;
        endcase
    end

    // Data is captured on the FETCH edge, so a same-edge write to that register is not seen.
    // Abort together with an accept still counts the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd_addr   <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_addr  <= '0;
            bus.word_cnt  <= '0;
            last_q        <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    bus.word_cnt <= '0;
                    if (bus.first_reg <= bus.last_reg) begin
                        last_q      <= bus.last_reg;
                        bus.rd_addr <= bus.first_reg;
                    end
                end
                FETCH: if (!bus.abort) begin
                    bus.out_data  <= bus.rd_data;
                    bus.out_addr  <= bus.rd_addr;
                    bus.out_valid <= 1'b1;
                end
                SEND: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.word_cnt  <= bus.word_cnt + 1'b1;
                        if (!bus.abort && bus.rd_addr != last_q) bus.rd_addr <= bus.rd_addr + 1'b1;
                    end
                    if (bus.abort) bus.out_valid <= 1'b0;
                end
                default: bus.rd_addr <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: directed self-checking bench for reg_dump_reader with a behavioural register file.
module tb_reg_dump_reader;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_dump_if #(.DW(DW), .AW(AW)) bus ();
    reg_dump_reader #(.DW(DW), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    logic [DW-1:0] regs [2**AW];
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    assign bus.rd_data = bus.rd_addr == '0 ? '0 : regs[bus.rd_addr];
    always @(posedge clk) if (wr_en) regs[wr_addr] <= wr_data;

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [AW-1:0] got_addr [$];
    logic [DW-1:0] got_data [$];
    int            done_cnt;
    int            done_cycle;
    int            valid_seen;
    int            stalled;
    logic [AW-1:0] addr_at_done;

    // Runs one dump; optionally stalls out_ready on word index stall_word for stall_len cycles
    // and optionally writes wr_val into r31 on r31's fetch edge.
    task automatic run(input int first, input int last, input int stall_word, input int stall_len,
                       input bit wr_trig, input logic [DW-1:0] wr_val);
        logic [DW-1:0] held;
        got_addr.delete();
        got_data.delete();
        done_cnt = 0;
        done_cycle = -1;
        valid_seen = 0;
        stalled = 0;
        held = '0;
        bus.first_reg = AW'(first);
        bus.last_reg = AW'(last);
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 200 && bus.busy; c++) begin
            wr_en = wr_trig && !bus.out_valid && !bus.done && bus.rd_addr == 5'd31;
            wr_addr = 5'd31;
            wr_data = wr_val;
            if (bus.out_valid) begin
                valid_seen++;
                if (got_addr.size() == stall_word && stalled < stall_len) begin
                    bus.out_ready = 1'b0;
                    if (stalled == 0) held = bus.out_data;
                    else check("stall_hold", bus.out_data, held);
                    stalled++;
                end else begin
                    bus.out_ready = 1'b1;
                    got_addr.push_back(bus.out_addr);
                    got_data.push_back(bus.out_data);
                end
            end
            if (bus.done) begin
                done_cnt++;
                if (done_cycle < 0) done_cycle = c;
                addr_at_done = bus.rd_addr;
            end
            step();
        end
        wr_en = 1'b0;
        check("dump_finished", bus.busy, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) regs[i] = 32'h100 + i;
        regs[1] = 32'h11;
        regs[2] = 32'h22;
        regs[3] = 32'h33;
        regs[30] = 32'h3030;
        regs[31] = 32'h3131;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        bus.start = 1'b0;
        bus.first_reg = '0;
        bus.last_reg = '0;
        bus.abort = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_cnt", bus.word_cnt, 0);
        rst_n = 1'b1;
        step();

        // Basic 1..3 dump with sink always ready.
        run(1, 3, -1, 0, 1'b0, '0);
        check("t2_words", got_addr.size(), 3);
        check("t2_a0", got_addr[0], 1);
        check("t2_d0", got_data[0], 32'h11);
        check("t2_a1", got_addr[1], 2);
        check("t2_d1", got_data[1], 32'h22);
        check("t2_a2", got_addr[2], 3);
        check("t2_d2", got_data[2], 32'h33);
        check("t2_done", done_cnt, 1);
        check("t2_cnt", bus.word_cnt, 3);
        check("t2_rdaddr", bus.rd_addr, 0);

        // Sink stalls 5 cycles on the second word.
        run(1, 3, 1, 5, 1'b0, '0);
        check("t3_stall_len", stalled, 5);
        check("t3_words", got_addr.size(), 3);
        check("t3_d1", got_data[1], 32'h22);
        check("t3_d2", got_data[2], 32'h33);
        check("t3_cnt", bus.word_cnt, 3);

        // r0 only, then an empty range.
        run(0, 0, -1, 0, 1'b0, '0);
        check("t4_words", got_addr.size(), 1);
        check("t4_a0", got_addr[0], 0);
        check("t4_d0", got_data[0], 0);
        check("t4_cnt", bus.word_cnt, 1);
        run(5, 4, -1, 0, 1'b0, '0);
        check("t4e_valid", valid_seen, 0);
        check("t4e_done", done_cnt, 1);
        check("t4e_done_cycle", done_cycle, 0);
        check("t4e_cnt", bus.word_cnt, 0);

        // Top-of-file range with a core write to r31 on its fetch edge.
        run(30, 31, -1, 0, 1'b1, 32'hDEAD);
        check("t5_words", got_addr.size(), 2);
        check("t5_d0", got_data[0], 32'h3030);
        check("t5_a1", got_addr[1], 31);
        check("t5_d1", got_data[1], 32'h3131);
        check("t5_wrote", regs[31], 32'hDEAD);
        check("t5_addr_done", addr_at_done, 31);
        check("t5_rdaddr", bus.rd_addr, 0);
        check("t5_cnt", bus.word_cnt, 2);

        // Abort during the second SEND; a Start while busy is ignored.
        bus.first_reg = 5'd1;
        bus.last_reg = 5'd3;
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        check("t6_v1", bus.out_valid, 1'b1);
        check("t6_a1", bus.out_addr, 1);
        bus.first_reg = 5'd7;
        bus.last_reg = 5'd9;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        check("t6_v2", bus.out_valid, 1'b1);
        check("t6_a2", bus.out_addr, 2);
        bus.out_ready = 1'b0;
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("t6_valid_fall", bus.out_valid, 1'b0);
        check("t6_busy", bus.busy, 1'b0);
        check("t6_no_done", bus.done, 1'b0);
        check("t6_cnt", bus.word_cnt, 1);
        step();
        check("t6_still_idle", bus.busy, 1'b0);
        check("t6_no_done2", bus.done, 1'b0);

        // Async reset while a word is pending.
        bus.first_reg = 5'd1;
        bus.last_reg = 5'd3;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        check("t1_pre_valid", bus.out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_valid", bus.out_valid, 1'b0);
        check("t1_data", bus.out_data, 0);
        check("t1_addr", bus.out_addr, 0);
        check("t1_rdaddr", bus.rd_addr, 0);
        check("t1_busy", bus.busy, 1'b0);
        check("t1_done", bus.done, 1'b0);
        check("t1_cnt", bus.word_cnt, 0);
        step();
        rst_n = 1'b1;
        step();
        check("t1_idle", bus.busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
